// File: rtl/linear_pkg.sv
// Shared types and width helpers for the sequential linear layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, accumulator width helper, counter width helper.
package linear_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Worst-case sum of nin products of two signed width-bit values:
    // each product needs 2*width bits, and nin of them add clog2(nin) bits.
    function automatic int acc_width(input int width, input int nin);
        return 2 * width + $clog2(nin);
    endfunction

    // Counter width for a count range 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: acc += a*b, with synchronous clear.
// Latency: sum is combinational (acc + a*b); acc updates on the next edge.
// Backpressure: none; en/clr are driven by the owning FSM each cycle.
//
// Ports: clk, rst_n (async active-low), en (accumulate), clr (zero acc,
//        wins over en), a/b (signed operands), sum (acc + a*b, ACCW bits).
module mac_unit #(
    parameter int WIDTH = 16,
    parameter int ACCW  = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACCW-1:0]  sum
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    acc;

    assign prod = a * b;
    // Size cast of a signed operand sign-extends to the accumulator width.
    assign sum  = acc + ACCW'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/seq_linear_layer.sv
// Matrix-vector layer out = sat(relu(W*in >>> FRAC)) using one shared MAC.
// Latency: accept at edge T -> out_valid after edge T+NIN*NOUT.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports: clk, rst_n (async active-low); in[NIN]/in_valid/in_ready input
//        handshake; out[NOUT]/out_valid/out_ready registered result handshake.
module seq_linear_layer
    import linear_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIN     = 4,
    parameter int NOUT    = 3,
    parameter int FRAC    = 0,
    parameter int RELU_EN = 0,
    parameter logic signed [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in [0:NIN-1],
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out [0:NOUT-1],
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int ACCW = acc_width(WIDTH, NIN);
    localparam int NW   = NIN * NOUT;
    localparam int CW   = cnt_width(NIN);
    localparam int RW   = cnt_width(NOUT);
    localparam int KW   = cnt_width(NW);

    // Saturation bounds sign-extended to the accumulator width.
    localparam logic signed [ACCW-1:0] SAT_MAX =
        {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN =
        {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [KW-1:0]           k;     // flat weight index row*NIN+col
    logic signed [WIDTH-1:0] in_q  [0:NIN-1];
    logic signed [WIDTH-1:0] w_rom [0:NW-1];
    logic signed [WIDTH-1:0] w_sel;
    logic signed [WIDTH-1:0] x_sel;
    logic signed [ACCW-1:0]  sum;
    logic signed [ACCW-1:0]  shifted;
    logic signed [ACCW-1:0]  rectified;
    logic signed [WIDTH-1:0] result;
    logic                    accept;
    logic                    mac_en;
    logic                    mac_clr;
    logic                    last_col;
    logic                    last_mac;

    // Unpack the flat weight parameter; row 0 col 0 sits in the MS word.
    for (genvar g = 0; g < NW; g++) begin : g_wrom
        assign w_rom[g] = WEIGHTS_MATRIX_FLAT[(NW-g)*WIDTH-1 -: WIDTH];
    end

    assign w_sel    = w_rom[k];
    assign x_sel    = in_q[col];
    assign last_col = (col == CW'(NIN-1));
    assign last_mac = last_col && (row == RW'(NOUT-1));

    mac_unit #(
        .WIDTH (WIDTH),
        .ACCW  (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .clr   (mac_clr),
        .a     (w_sel),
        .b     (x_sel),
        .sum   (sum)
    );

    // Post-processing of the completed row sum: shift, optional ReLU, clamp.
    always_comb begin
        shifted   = sum >>> FRAC;
        rectified = shifted;
        if ((RELU_EN != 0) && shifted[ACCW-1]) begin
            rectified = '0;
        end
        if (rectified > SAT_MAX) begin
            result = SAT_MAX[WIDTH-1:0];
        end else if (rectified < SAT_MIN) begin
            result = SAT_MIN[WIDTH-1:0];
        end else begin
            result = rectified[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    mac_clr   = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                // The final product of a row goes straight to out via sum,
                // so the accumulator restarts at zero for the next row.
                mac_clr = last_col;
                if (last_mac) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            k   <= '0;
            for (int i = 0; i < NIN; i++) begin
                in_q[i] <= '0;
            end
            for (int i = 0; i < NOUT; i++) begin
                out[i] <= '0;
            end
        end else begin
            if (accept) begin
                in_q <= in;
                col  <= '0;
                row  <= '0;
                k    <= '0;
            end
            if (mac_en) begin
                if (last_col) begin
                    out[row] <= result;
                    col      <= '0;
                    row      <= last_mac ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                k <= last_mac ? '0 : k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_linear_layer.sv
// Self-checking bench for seq_linear_layer: plain, ReLU and FRAC=3 instances.
// Latency: checks accept-to-out_valid distance of NIN*NOUT edges.
// Backpressure: exercises out_ready stalls and in_valid held during COMPUTE.
module tb_seq_linear_layer;

    localparam int NI = 4;
    localparam int NO = 3;

    localparam logic signed [16*NI*NO-1:0] WF = {
        16'sd30,   16'sd780, -16'sd25,  -16'sd77,
        16'sd308, -16'sd78,  -16'sd250, -16'sd779,
        -16'sd302, 16'sd788, -16'sd250, -16'sd77
    };

    typedef logic [NI-1:0][15:0] pin_t;
    typedef logic [NO-1:0][15:0] pout_t;

    typedef struct packed {
        pin_t  x;
        pout_t ea;
        pout_t eb;
    } vec_t;

    typedef struct packed {
        pout_t ea;
        pout_t eb;
        pout_t ec;
        int    acc_edge;
    } exp_t;

    int wt [NO][NI] = '{'{30, 780, -25, -77},
                        '{308, -78, -250, -779},
                        '{-302, 788, -250, -77}};

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] in_v  [0:NI-1];
    logic               in_valid;
    logic               out_ready;
    logic               in_ready_a, in_ready_b, in_ready_c;
    logic               out_valid_a, out_valid_b, out_valid_c;
    logic signed [15:0] out_a [0:NO-1];
    logic signed [15:0] out_b [0:NO-1];
    logic signed [15:0] out_c [0:NO-1];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   seen = 1'b0;
    exp_t sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_linear_layer #(.WIDTH(16), .NIN(NI), .NOUT(NO), .FRAC(0), .RELU_EN(0),
                       .WEIGHTS_MATRIX_FLAT(WF)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in_v), .in_valid(in_valid),
        .in_ready(in_ready_a), .out(out_a), .out_valid(out_valid_a),
        .out_ready(out_ready));

    seq_linear_layer #(.WIDTH(16), .NIN(NI), .NOUT(NO), .FRAC(0), .RELU_EN(1),
                       .WEIGHTS_MATRIX_FLAT(WF)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_v), .in_valid(in_valid),
        .in_ready(in_ready_b), .out(out_b), .out_valid(out_valid_b),
        .out_ready(out_ready));

    seq_linear_layer #(.WIDTH(16), .NIN(NI), .NOUT(NO), .FRAC(3), .RELU_EN(0),
                       .WEIGHTS_MATRIX_FLAT(WF)) dut_c (
        .clk(clk), .rst_n(rst_n), .in(in_v), .in_valid(in_valid),
        .in_ready(in_ready_c), .out(out_c), .out_valid(out_valid_c),
        .out_ready(out_ready));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic pin_t v4(input int a, input int b, input int c, input int d);
        pin_t r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        return r;
    endfunction

    function automatic pout_t v3(input int a, input int b, input int c);
        pout_t r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        return r;
    endfunction

    // Reference: full-precision dot product, shift, ReLU, clamp.
    function automatic pout_t model(input pin_t x, input int frac, input bit relu);
        pout_t r;
        for (int i = 0; i < NO; i++) begin
            longint s;
            s = 0;
            for (int j = 0; j < NI; j++) begin
                s += longint'(wt[i][j]) * longint'($signed(x[j]));
            end
            s = s >>> frac;
            if (relu && s < 0) s = 0;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            r[i] = 16'(s);
        end
        return r;
    endfunction

    // Caller is positioned just after a rising edge.
    task automatic send(input pin_t x, input pout_t ea, input pout_t eb);
        exp_t e;
        int   t;
        for (int j = 0; j < NI; j++) in_v[j] = $signed(x[j]);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_a) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            e.ea       = ea;
            e.eb       = eb;
            e.ec       = model(x, 3, 1'b0);
            e.acc_edge = cyc + 1;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            // The captured copy must be used from here on.
            for (int j = 0; j < NI; j++) in_v[j] = 16'($urandom);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: latency on first sight, values on the handshake cycle.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid_a) begin
                if (sb_q.size() == 0) begin
                    if (out_ready) check("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc - sb_q[0].acc_edge, NI * NO);
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        cur = sb_q.pop_front();
                        for (int i = 0; i < NO; i++) begin
                            check($sformatf("out_plain[%0d]", i), out_a[i], $signed(cur.ea[i]));
                            check($sformatf("out_relu[%0d]", i), out_b[i], $signed(cur.eb[i]));
                            check($sformatf("out_frac3[%0d]", i), out_c[i], $signed(cur.ec[i]));
                        end
                        check("valid_relu_frac", int'(out_valid_b & out_valid_c), 1);
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        vec_t  tbl [5];
        pout_t ea1, eb1;
        pin_t  xr;
        int    t;

        ea1 = v3(1207, -3714, 216);
        eb1 = v3(1207, 0, 216);
        tbl[0] = '{x: v4(1, 2, 3, 4),         ea: ea1,                        eb: eb1};
        tbl[1] = '{x: v4(-200, 35, 77, -256), ea: v3(32767, 32767, 32767),    eb: v3(32767, 32767, 32767)};
        tbl[2] = '{x: v4(200, -35, -77, 256), ea: v3(-32768, -32768, -32768), eb: v3(0, 0, 0)};
        tbl[3] = '{x: v4(0, 0, 0, 0),         ea: v3(0, 0, 0),                eb: v3(0, 0, 0)};
        tbl[4] = '{x: v4(-1, -2, -3, -4),     ea: v3(-1207, 3714, -216),      eb: v3(0, 3714, 0)};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < NI; j++) in_v[j] = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready_a & in_ready_b & in_ready_c), 1);
        check("rst_out_valid", int'(out_valid_a | out_valid_b | out_valid_c), 0);
        for (int i = 0; i < NO; i++) check("rst_out", out_a[i], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors issued back to back.
        for (int n = 0; n < 5; n++) send(tbl[n].x, tbl[n].ea, tbl[n].eb);
        drain();

        // Downstream stall for 20 cycles in DONE.
        out_ready = 1'b0;
        send(v4(1, 2, 3, 4), ea1, eb1);
        t = 0;
        @(negedge clk);
        while (!out_valid_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("stall_reach_done", int'(out_valid_a), 1);
        for (int c = 0; c < 20; c++) begin
            check("stall_out_valid", int'(out_valid_a), 1);
            check("stall_in_ready", int'(in_ready_a), 0);
            for (int i = 0; i < NO; i++) check("stall_out", out_a[i], $signed(ea1[i]));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_stall_in_ready", int'(in_ready_a), 1);
        check("post_stall_out_valid", int'(out_valid_a), 0);
        for (int i = 0; i < NO; i++) check("out_retained", out_a[i], $signed(ea1[i]));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of COMPUTE.
        send(v4(-200, 35, 77, -256), v3(32767, 32767, 32767), v3(32767, 32767, 32767));
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", int'(in_ready_a), 1);
        check("arst_out_valid", int'(out_valid_a), 0);
        for (int i = 0; i < NO; i++) check("arst_out", out_a[i], 0);
        sb_q.delete();
        seen = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_no_valid", int'(out_valid_a), 0);
        check("post_rst_in_ready", int'(in_ready_a), 1);
        @(posedge clk);
        #1;
        send(v4(1, 2, 3, 4), ea1, eb1);
        drain();

        // Random back-to-back vectors; inputs scrambled during COMPUTE.
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < NI; j++) begin
                if (n % 2 == 0) xr[j] = 16'($urandom);
                else xr[j] = 16'($urandom_range(0, 4000) - 2000);
            end
            send(xr, model(xr, 0, 1'b0), model(xr, 0, 1'b1));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_linear_layer.md
SEQ_LINEAR_LAYER -- requirements
Module: seq_linear_layer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed data/weight width in bits.
REQ-002 SHALL have parameter NIN, default 4, input vector length (>=1).
REQ-003 SHALL have parameter NOUT, default 3, output vector length (>=1).
REQ-004 SHALL have parameter FRAC, default 0, fixed-point fraction bits removed from each result by arithmetic right shift.
REQ-005 SHALL have parameter RELU_EN, default 0; 1 clamps negative results to 0.
REQ-006 SHALL have parameter WEIGHTS_MATRIX_FLAT, signed [WIDTH*NIN*NOUT-1:0], row-major, row 0 col 0 in the MS word: W[i][j] = FLAT[(NIN*NOUT-(i*NIN+j))*WIDTH-1 -: WIDTH].
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 in  input  signed [WIDTH-1:0] x [0:NIN-1]  input vector.
REQ-010 in_valid  input  1  in holds a valid vector.
REQ-011 in_ready  output  1  block accepts a vector this cycle.
REQ-012 out  output  signed [WIDTH-1:0] x [0:NOUT-1]  result vector, registered.
REQ-013 out_valid  output  1  out holds a valid result.
REQ-014 out_ready  input  1  downstream accepts out this cycle.

Function
REQ-015 SHALL compute out[i] = sat(relu(sum_j W[i][j]*in[j] >>> FRAC)) for i in 0..NOUT-1.
REQ-016 SHALL use one shared signed WIDTHxWIDTH multiplier, one product per cycle, iterating j fastest, then i.
REQ-017 SHALL accumulate in ACCW = 2*WIDTH + clog2(NIN) signed bits; no intermediate overflow.
REQ-018 SHALL saturate each shifted result to [-2^(WIDTH-1), 2^(WIDTH-1)-1] after optional ReLU.
REQ-019 FSM states IDLE, COMPUTE, DONE; reset state IDLE.
REQ-020 IDLE: in_ready=1; in_valid&in_ready captures in into an internal register, clears accumulator, -> COMPUTE.
REQ-021 COMPUTE: in_ready=0; one MAC per cycle; at j=NIN-1 writes out[i] register, clears accumulator; after i=NOUT-1, j=NIN-1 -> DONE.
REQ-022 DONE: out_valid=1, out stable; out_valid&out_ready -> IDLE; otherwise hold indefinitely.
REQ-023 Latency: vector accepted at edge T -> out_valid high after edge T+NIN*NOUT; throughput one vector per NIN*NOUT+2 cycles minimum.
REQ-024 in changes while in COMPUTE/DONE SHALL not affect the result (captured copy used).
REQ-025 in_valid ignored outside IDLE; out_ready ignored outside DONE.
REQ-026 out registers SHALL retain previous result until overwritten row-by-row in the next COMPUTE.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, in_ready=1, out_valid=0, all out=0, counters and accumulator 0.
REQ-028 Reset mid-COMPUTE or mid-DONE SHALL discard the in-flight vector; no out_valid after release until a new accept.

Structure
REQ-029 Package linear_pkg SHALL hold the FSM state enum and a clog2-based ACCW helper function.
REQ-030 Sub-module mac_unit (signed multiply, accumulate, clear, ACCW-wide) SHALL be instantiated once.

Verification
REQ-031 Weights rows {30,780,-25,-77},{308,-78,-250,-779},{-302,788,-250,-77}, in={1,2,3,4}, FRAC=0 -> out={1207,-3714,216}, out_valid after 12 cycles.
REQ-032 Same weights, in={-200,35,77,-256} -> sums 39087,115844,88442 -> out={32767,32767,32767} (positive saturation).
REQ-033 RELU_EN=1, in={1,2,3,4} -> out={1207,0,216}.
REQ-034 out_ready held low 20 cycles in DONE -> out_valid and out stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle.
REQ-035 rst_n pulsed low at COMPUTE cycle 5 -> out_valid=0, out all 0, in_ready=1 asynchronously; new vector {1,2,3,4} -> {1207,-3714,216}.
REQ-036 Back-to-back vectors with in changing during COMPUTE -> each result matches its captured vector.
